// File: rtl/geofence_pkg.sv
// Shared types and constants for the geofence stimulus driver.
//   state_e  : driver FSM states
//   point_t  : one unpacked X/Y/R point
//   ROM word layout: header [31]=eof, [30]=golden; point [30:21]=X, [20:11]=Y, [10:0]=R
package geofence_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_HDR,
    CHK_HDR,
    STREAM,
    WAIT,
    DONE
  } state_e;

  localparam int unsigned DEF_NPTS       = 6;

  localparam int unsigned HDR_EOF_BIT    = 31;
  localparam int unsigned HDR_GOLDEN_BIT = 30;

  localparam int unsigned PT_X_W         = 10;
  localparam int unsigned PT_Y_W         = 10;
  localparam int unsigned PT_R_W         = 11;
  localparam int unsigned PT_MSB         = PT_X_W + PT_Y_W + PT_R_W - 1;

  // Field order matches the ROM word, so X lands in [30:21] and R in [10:0].
  typedef struct packed {
    logic [PT_X_W-1:0] x;
    logic [PT_Y_W-1:0] y;
    logic [PT_R_W-1:0] r;
  } point_t;

  function automatic point_t unpack_point(input logic [PT_MSB:0] w);
    return point_t'(w);
  endfunction

endpackage

// File: rtl/geofence_score.sv
// Result scoring for the geofence driver.
//   clk, reset     : clock, synchronous active-high reset
//   clr_i          : clear both counters (accepted start)
//   score_i        : a result is being scored this cycle
//   miss_i         : object timed out this cycle (counts as a fail)
//   golden_i       : expected is_inside for the current object
//   is_inside_i    : geofence answer, meaningful with score_i
//   pass_cnt_o     : saturating count of matching results
//   fail_cnt_o     : saturating count of mismatches and timeouts
module geofence_score #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             score_i,
  input  logic             miss_i,
  input  logic             golden_i,
  input  logic             is_inside_i,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (clr_i) begin
      pass_d = '0;
      fail_d = '0;
    end else if (score_i) begin
      if (is_inside_i == golden_i) begin
        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
      end else begin
        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
      end
    end else if (miss_i) begin
      if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass_cnt_o = pass_q;
  assign fail_cnt_o = fail_q;

endmodule

// File: rtl/geofence_stim_driver.sv
// ROM-driven stimulus driver for the geofence X/Y/R point interface.
// Walks a packed ROM image of objects (1 header + NPTS points each), streams
// the points on consecutive cycles, waits for the geofence result and scores
// it against the header's golden bit.
//   clk, reset          : clock, synchronous active-high reset
//   start               : pulse; accepted in IDLE or DONE (DONE also clears results)
//   rom_addr            : ROM read address (equals the fetch pointer)
//   rom_data            : ROM word, one cycle after rom_addr
//   X, Y, R             : registered point outputs
//   valid, is_inside    : geofence result strobe and answer
//   busy, done          : activity / completion status
//   pass_cnt, fail_cnt  : saturating result counters
//   timeout             : sticky, set when a result never arrived
module geofence_stim_driver
  import geofence_pkg::*;
#(
  parameter int unsigned NPTS    = DEF_NPTS,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [PT_X_W-1:0] X,
  output logic [PT_Y_W-1:0] Y,
  output logic [PT_R_W-1:0] R,
  input  logic              valid,
  input  logic              is_inside,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              timeout
);

  localparam int unsigned KW = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [KW-1:0] K_LAST  = KW'(NPTS - 1);
  localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [KW-1:0]     k_q, k_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              golden_q, golden_d;
  logic [PT_X_W-1:0] x_q, x_d;
  logic [PT_Y_W-1:0] y_q, y_d;
  logic [PT_R_W-1:0] r_q, r_d;
  logic              tmo_q, tmo_d;

  logic   start_ok, ptr_inc, score_en, tmo_fail;
  logic   hdr_eof, last_pt, wait_hit;
  point_t pt;

  assign hdr_eof  = rom_data[HDR_EOF_BIT];
  assign pt       = unpack_point(rom_data[PT_MSB:0]);
  assign last_pt  = (k_q == K_LAST);
  // Timer holds the number of WAIT cycles including the current one.
  assign wait_hit = (tmr_q == T_LIMIT);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = FETCH_HDR;
      FETCH_HDR: state_d = CHK_HDR;
      CHK_HDR:   state_d = hdr_eof ? DONE : STREAM;
      STREAM:    if (last_pt) state_d = WAIT;
      WAIT: begin
        if (valid)         state_d = FETCH_HDR;
        else if (wait_hit) state_d = DONE;
      end
      DONE:      if (start) state_d = FETCH_HDR;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    start_ok = 1'b0;
    ptr_inc  = 1'b0;
    score_en = 1'b0;
    tmo_fail = 1'b0;
    unique case (state_q)
      IDLE:      start_ok = start;
      FETCH_HDR: begin busy = 1'b1; ptr_inc = 1'b1; end
      CHK_HDR:   begin busy = 1'b1; ptr_inc = !hdr_eof; end
      STREAM:    begin busy = 1'b1; ptr_inc = !last_pt; end
      WAIT: begin
        busy     = 1'b1;
        score_en = valid;
        // A result arriving on the final WAIT cycle is scored, not timed out.
        tmo_fail = !valid && wait_hit;
      end
      DONE:      begin done = 1'b1; start_ok = start; end
      default:   ;
    endcase
  end

  // Datapath next state
  always_comb begin
    ptr_d    = ptr_q;
    k_d      = k_q;
    tmr_d    = tmr_q;
    golden_d = golden_q;
    x_d      = x_q;
    y_d      = y_q;
    r_d      = r_q;
    tmo_d    = tmo_q;

    if (start_ok)     ptr_d = '0;
    else if (ptr_inc) ptr_d = ptr_q + 1'b1;

    if (state_q == CHK_HDR) begin
      k_d      = '0;
      golden_d = rom_data[HDR_GOLDEN_BIT];
    end

    if (state_q == STREAM) begin
      k_d = k_q + 1'b1;
      x_d = pt.x;
      y_d = pt.y;
      r_d = pt.r;
      if (last_pt) tmr_d = TW'(1);
    end else if (state_q == WAIT) begin
      tmr_d = tmr_q + 1'b1;
    end

    if (start_ok)      tmo_d = 1'b0;
    else if (tmo_fail) tmo_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      k_q      <= '0;
      tmr_q    <= '0;
      golden_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      r_q      <= '0;
      tmo_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      k_q      <= k_d;
      tmr_q    <= tmr_d;
      golden_q <= golden_d;
      x_q      <= x_d;
      y_q      <= y_d;
      r_q      <= r_d;
      tmo_q    <= tmo_d;
    end
  end

  geofence_score #(
    .CNT_W(CNT_W)
  ) u_score (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (start_ok),
    .score_i    (score_en),
    .miss_i     (tmo_fail),
    .golden_i   (golden_q),
    .is_inside_i(is_inside),
    .pass_cnt_o (pass_cnt),
    .fail_cnt_o (fail_cnt)
  );

  assign rom_addr = ptr_q;
  assign X        = x_q;
  assign Y        = y_q;
  assign R        = r_q;
  assign timeout  = tmo_q;

endmodule

// File: tb/tb_geofence_stim_driver.sv
// Directed bench for geofence_stim_driver with a cycle-level reference model.
// The model tracks each object by its header address and the cycle offset
// since its header fetch, deriving outputs from the documented timing.
module tb_geofence_stim_driver;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned TMO    = 16;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CMAX   = (1 << CNT_W) - 1;
  localparam logic [31:0] EOFW   = 32'hC000_00FF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              valid = 1'b0;
  logic              is_inside = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data = '0;
  logic [9:0]        X, Y;
  logic [10:0]       R;
  logic              busy, done, timeout;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;

  logic [31:0] rom [0:4095];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  geofence_stim_driver #(
    .NPTS(6), .ADDR_W(ADDR_W), .TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .X(X), .Y(Y), .R(R), .valid(valid),
    .is_inside(is_inside), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (done !== 1'b1 && n < budget) begin tick(1); n++; end
    chk(name, done, 1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = '0;
  endtask

  // Object o, point i: X=100*o+i, Y=900-10*i-o, R=2000+3*i+o; bit 31 set as junk.
  task automatic load_obj(input int unsigned a, input int unsigned o, input logic golden);
    rom[a] = {1'b0, golden, 30'h0123_4567};
    for (int unsigned i = 1; i <= 6; i++)
      rom[a + i] = {1'b1, 10'(100 * o + i), 10'(900 - 10 * i - o), 11'(2000 + 3 * i + o)};
  endtask

  // ---------------- reference model ----------------
  bit          m_ok = 0, m_run = 0, m_done = 0, m_tmo = 0;
  int unsigned m_pass = 0, m_fail = 0, m_off = 0;
  logic [11:0] m_base = '0;
  logic [9:0]  m_x = '0, m_y = '0;
  logic [10:0] m_r = '0;

  function automatic int unsigned sat(input int unsigned v);
    return (v == CMAX) ? v : v + 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ok <= 1; m_run <= 0; m_done <= 0; m_tmo <= 0; m_pass <= 0; m_fail <= 0;
      m_base <= '0; m_off <= 0; m_x <= '0; m_y <= '0; m_r <= '0;
    end else if (!m_run) begin
      if (start) begin
        if (m_done) begin m_pass <= 0; m_fail <= 0; m_tmo <= 0; end
        m_run <= 1; m_done <= 0; m_base <= '0; m_off <= 0;
      end
    end else if (m_off == 1 && rom[m_base][31]) begin
      m_run <= 0; m_done <= 1;
    end else if (m_off >= 8) begin
      if (valid) begin
        if (is_inside == rom[m_base][30]) m_pass <= sat(m_pass);
        else m_fail <= sat(m_fail);
        m_base <= m_base + 12'd7;
        m_off <= 0;
      end else if (m_off - 7 == TMO) begin
        m_fail <= sat(m_fail); m_tmo <= 1; m_run <= 0; m_done <= 1;
      end else begin
        m_off <= m_off + 1;
      end
    end else begin
      m_off <= m_off + 1;
      if (m_off >= 2) begin
        m_x <= rom[m_base + 12'(m_off - 1)][30:21];
        m_y <= rom[m_base + 12'(m_off - 1)][20:11];
        m_r <= rom[m_base + 12'(m_off - 1)][10:0];
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] ea;
    if (m_ok) begin
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("pass_cnt", pass_cnt, m_pass);
      chk("fail_cnt", fail_cnt, m_fail);
      chk("timeout", timeout, m_tmo);
      chk("X", X, m_x);
      chk("Y", Y, m_y);
      chk("R", R, m_r);
      if (m_run && m_off <= 6 && !(m_off == 1 && rom[m_base][31])) begin
        ea = m_base + 12'(m_off);
        chk("rom_addr", rom_addr, ea);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [9:0]  bx [6];
    logic [9:0]  by [6];
    logic [10:0] br [6];
    bx = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};
    by = '{10'd890, 10'd880, 10'd870, 10'd860, 10'd850, 10'd840};
    br = '{11'd2003, 11'd2006, 11'd2009, 11'd2012, 11'd2015, 11'd2018};

    clear_rom();
    reset = 1; tick(2);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_pass", pass_cnt, 0); chk("rst_fail", fail_cnt, 0);
    chk("rst_tmo", timeout, 0); chk("rst_X", X, 0); chk("rst_R", R, 0);
    reset = 0; tick(1);

    // A: one passing object, result on third WAIT cycle
    load_obj(0, 0, 1'b1); rom[7] = EOFW;
    start = 1; tick(1); start = 0;
    tick(10);
    chk("A_busy_wait", busy, 1);
    valid = 1; is_inside = 1; tick(1); valid = 0; is_inside = 0;
    wait_done("A_done", 40);
    chk("A_pass", pass_cnt, 1); chk("A_fail", fail_cnt, 0); chk("A_lastX", X, 6);

    // B: two objects, second mismatches; exact point timing
    clear_rom(); load_obj(0, 0, 1'b1); load_obj(7, 1, 1'b0); rom[14] = EOFW;
    start = 1; tick(1); start = 0;
    chk("B_clr_pass", pass_cnt, 0);
    tick(3);
    for (int i = 0; i < 6; i++) begin
      chk("B_ptX", X, bx[i]); chk("B_ptY", Y, by[i]); chk("B_ptR", R, br[i]);
      if (i < 5) tick(1);
    end
    valid = 1; is_inside = 1; tick(1); valid = 0;
    tick(3);
    chk("B_o1X", X, 101); chk("B_o1Y", Y, 889); chk("B_o1R", R, 2004);
    tick(6);
    valid = 1; is_inside = 1; tick(1); valid = 0; is_inside = 0;
    wait_done("B_done", 40);
    chk("B_pass", pass_cnt, 1); chk("B_fail", fail_cnt, 1);

    // C: valid only during STREAM, then timeout
    clear_rom(); load_obj(0, 2, 1'b1); rom[7] = EOFW;
    start = 1; tick(1); start = 0;
    tick(3);
    valid = 1; is_inside = 1; tick(1); valid = 0; is_inside = 0;
    tick(19);
    chk("C_busy24", busy, 1); chk("C_done24", done, 0);
    tick(1);
    chk("C_done25", done, 1); chk("C_fail", fail_cnt, 1);
    chk("C_pass", pass_cnt, 0); chk("C_tmo", timeout, 1);
    reset = 1; tick(1);
    chk("C_rst_fail", fail_cnt, 0); chk("C_rst_tmo", timeout, 0); chk("C_rst_done", done, 0);
    reset = 0;

    // C2: valid on the final WAIT cycle wins over timeout
    start = 1; tick(1); start = 0;
    tick(23);
    valid = 1; is_inside = 1; tick(1); valid = 0; is_inside = 0;
    chk("C2_pass", pass_cnt, 1); chk("C2_tmo", timeout, 0); chk("C2_busy", busy, 1);
    wait_done("C2_done", 40);

    // D: reset on third STREAM cycle, then restart from address 0
    start = 1; tick(1); start = 0;
    tick(4);
    reset = 1; tick(1);
    chk("D_X", X, 0); chk("D_Y", Y, 0); chk("D_R", R, 0);
    chk("D_busy", busy, 0); chk("D_addr", rom_addr, 0);
    reset = 0;
    start = 1; tick(1); start = 0;
    chk("D_addr0", rom_addr, 0);
    tick(1);
    chk("D_addr1", rom_addr, 1);
    tick(7);
    valid = 1; is_inside = 0; tick(1); valid = 0;
    wait_done("D_done", 40);
    chk("D_fail", fail_cnt, 1); chk("D_pass", pass_cnt, 0);

    // E: five passes saturate at 3; start in DONE clears
    clear_rom();
    for (int unsigned o = 0; o < 5; o++) load_obj(7 * o, o, o[0]);
    rom[35] = EOFW;
    start = 1; tick(1); start = 0;
    for (int unsigned o = 0; o < 5; o++) begin
      tick(8); valid = 1; is_inside = o[0]; tick(1); valid = 0;
    end
    wait_done("E_done", 40);
    chk("E_pass_sat", pass_cnt, 3); chk("E_fail", fail_cnt, 0);
    start = 1; tick(1); start = 0;
    chk("E_clr_pass", pass_cnt, 0); chk("E_clr_done", done, 0);
    for (int unsigned o = 0; o < 5; o++) begin
      tick(8); valid = 1; is_inside = !o[0]; tick(1); valid = 0;
    end
    wait_done("E_done2", 40);
    chk("E_fail_sat", fail_cnt, 3); chk("E_pass0", pass_cnt, 0);

    // F: eof at word 0
    reset = 1; tick(1); reset = 0;
    clear_rom(); rom[0] = EOFW;
    start = 1; tick(1); start = 0;
    tick(1);
    chk("F_busy_t2", busy, 1); chk("F_done_t2", done, 0);
    tick(1);
    chk("F_done_t3", done, 1); chk("F_pass", pass_cnt, 0); chk("F_fail", fail_cnt, 0);
    chk("F_X", X, 0); chk("F_Y", Y, 0); chk("F_R", R, 0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
